confreg_resp: RTL



---
 rtl/confreg_resp.sv | 94 +++++++++
 1 files changed

// File: rtl/confreg_resp.sv
// confreg_resp: LED/NUM/SWITCH/TIMER config registers on the data SRAM bus, one-cycle read latency.
// Timer, compare and irq status exist only when CONFREG_TIMER_EN is defined.
module confreg_resp #(
   parameter logic [15:0] BASE_HI  = 16'hBFAF,
   parameter int          SWITCH_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sram_en,
   input  logic [3:0]          sram_wen,
   input  logic [31:0]         sram_addr,
   input  logic [31:0]         sram_wdata,
   output logic [31:0]         sram_rdata,
   input  logic [SWITCH_W-1:0] switch_in,
   output logic [15:0]         led,
   output logic [31:0]         num_data,
   output logic                timer_int
);
   localparam logic [13:0] A_LED = 14'h2000;
   localparam logic [13:0] A_NUM = 14'h3C04;
   localparam logic [13:0] A_SW  = 14'h3C08;
   localparam logic [13:0] A_TMR = 14'h3C00;
   localparam logic [13:0] A_CMP = 14'h3C01;
   localparam logic [13:0] A_ST  = 14'h3C02;
   logic                hit, wr, rd, rd_map;
   logic [13:0]         sel;
   logic [31:0]         bmask, rd_val;
   logic [SWITCH_W-1:0] sw_s1, sw_s2;
   logic                unused_addr;
   assign unused_addr = ^sram_addr[1:0];
   assign sel   = sram_addr[15:2];
   assign hit   = sram_en && sram_addr[31:16] == BASE_HI;
   assign wr    = hit && sram_wen != 4'b0000;
   assign rd    = hit && sram_wen == 4'b0000;
   assign bmask = {{8{sram_wen[3]}}, {8{sram_wen[2]}}, {8{sram_wen[1]}}, {8{sram_wen[0]}}};
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [31:0] m);
      return (old & ~m) | (wd & m);
   endfunction
`ifdef CONFREG_TIMER_EN
   logic [31:0] timer, compare;
   logic        status;
   always_ff @(posedge clk) begin
      if (rst) begin
         timer   <= 32'h0;
         compare <= 32'hFFFF_FFFF;
         status  <= 1'b0;
      end else begin
         timer <= (wr && sel == A_TMR) ? merge(timer, sram_wdata, bmask) : timer + 32'd1;
         if (wr && sel == A_CMP)
            compare <= merge(compare, sram_wdata, bmask);
         // a fresh compare value invalidates a same-cycle match; a match beats W1C
         status <= (wr && sel == A_CMP) ? 1'b0 :
                   (timer == compare) ? 1'b1 :
                   (wr && sel == A_ST && sram_wen[0] && sram_wdata[0]) ? 1'b0 : status;
      end
   end
   assign timer_int = status;
`else
   assign timer_int = 1'b0;
`endif
   always_comb begin
      rd_map = 1'b1;
      rd_val = 32'h0;
      case (sel)
         A_LED: rd_val = {16'h0, led};
         A_NUM: rd_val = num_data;
         A_SW:  rd_val = 32'(sw_s2);
`ifdef CONFREG_TIMER_EN
         A_TMR: rd_val = timer;
         A_CMP: rd_val = compare;
         A_ST:  rd_val = {31'h0, status};
`endif
         default: rd_map = 1'b0;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sram_rdata <= 32'h0;
         led        <= 16'hFFFF;
         num_data   <= 32'h0;
         sw_s1      <= '0;
         sw_s2      <= '0;
      end else begin
         sw_s1 <= switch_in;
         sw_s2 <= sw_s1;
         if (rd && rd_map)
            sram_rdata <= rd_val;
         if (wr && sel == A_LED)
            led <= (led & ~bmask[15:0]) | (sram_wdata[15:0] & bmask[15:0]);
         if (wr && sel == A_NUM)
            num_data <= merge(num_data, sram_wdata, bmask);
      end
   end
endmodule
